// File: rtl/uart_block_assembler.sv
`timescale 1ns/1ps
// Packs the uart_rx byte stream into 128-bit AES blocks (first byte in the MSBs) and presents
// each block on valid/ready, flagging dropped bytes and discarding stale partial blocks.
module uart_block_assembler #(
  parameter int TIMEOUT_CYCLES = 43_400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  input  logic         block_ready,
  output logic [127:0] block_out,
  output logic         block_valid,
  output logic [4:0]   byte_count,
  output logic         overrun,
  output logic         timeout
);

  localparam int TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Expiry is detected one count early so the counter never has to hold TIMEOUT_CYCLES itself.
  localparam logic [TCW-1:0] TCNT_LAST =
    (TIMEOUT_CYCLES > 0) ? TCW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   block_q, block_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           ovr_q, ovr_d;
  logic           to_q, to_d;

  logic           capture;
  logic [3:0]     wr_idx;

  // A byte in HOLD is only taken when the handshake frees the buffer on the same edge.
  assign capture = data_valid && ((state_q == COLLECT) || block_ready);
  assign wr_idx  = (state_q == HOLD) ? 4'd0 : cnt_q[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      block_q <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (data_valid && (cnt_q == 5'd15)) state_d = HOLD;
      HOLD:    if (block_ready)                    state_d = COLLECT;
    endcase
  end

  always_comb begin
    block_d = block_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    ovr_d   = 1'b0;
    to_d    = 1'b0;
    if (capture) begin
      // Byte n lands at bit offset 8*(15-n), i.e. {~n, 3'b000}.
      block_d[{~wr_idx, 3'b000} +: 8] = data_in;
      cnt_d  = (state_q == HOLD) ? 5'd1 : cnt_q + 5'd1;
      tcnt_d = '0;
    end else if (state_q == HOLD) begin
      if (block_ready) begin
        cnt_d = '0;
      end else if (data_valid) begin
        ovr_d = 1'b1;
      end
    end else if ((TIMEOUT_CYCLES > 0) && (cnt_q != 5'd0)) begin
      if (tcnt_q == TCNT_LAST) begin
        cnt_d  = '0;
        tcnt_d = '0;
        to_d   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    block_out   = block_q;
    block_valid = (state_q == HOLD);
    byte_count  = cnt_q;
    overrun     = ovr_q;
    timeout     = to_q;
  end

endmodule

// File: tb/tb_uart_block_assembler.sv
`timescale 1ns/1ps
// Randomized and directed bench for uart_block_assembler against a queue-based block model,
// plus a serial end-to-end path into a second instance at default timeout.
module tb_uart_block_assembler;

  localparam int TMO = 100;
  localparam int BIT = 434;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   data_in = '0;
  logic         data_valid = 1'b0;
  logic         block_ready = 1'b0;
  logic [127:0] block_out;
  logic         block_valid;
  logic [4:0]   byte_count;
  logic         overrun;
  logic         timeout;

  logic         rst2 = 1'b1;
  logic [7:0]   d2 = '0;
  logic         dv2 = 1'b0;
  logic         ready2 = 1'b0;
  logic [127:0] block_out2;
  logic         block_valid2;
  logic [4:0]   byte_count2;
  logic         overrun2;
  logic         timeout2;
  logic         ser = 1'b1;

  int n_chk = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  uart_block_assembler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .block_ready(block_ready), .block_out(block_out), .block_valid(block_valid),
    .byte_count(byte_count), .overrun(overrun), .timeout(timeout)
  );

  uart_block_assembler dut2 (
    .clk(clk), .rst(rst2), .data_in(d2), .data_valid(dv2),
    .block_ready(ready2), .block_out(block_out2), .block_valid(block_valid2),
    .byte_count(byte_count2), .overrun(overrun2), .timeout(timeout2)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the bytes of the block being gathered, the image shown on block_out,
  // whether a full block is waiting, and how long the line has been idle.
  logic [7:0] m_q[$];
  logic [7:0] m_mem[16];
  bit         m_held;
  int         m_idle;
  bit         m_ovr, m_to;

  function automatic void model_reset();
    m_q.delete();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_held = 0; m_idle = 0; m_ovr = 0; m_to = 0;
  endfunction

  function automatic void model_step(input bit dv, input logic [7:0] d, input bit rdy);
    m_ovr = 0;
    m_to  = 0;
    if (m_held) begin
      if (rdy) begin
        m_held = 0;
        m_q.delete();
        m_idle = 0;
        if (dv) begin
          m_mem[0] = d;
          m_q.push_back(d);
        end
      end else if (dv) begin
        m_ovr = 1;
      end
    end else if (dv) begin
      m_mem[m_q.size()] = d;
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == 16) m_held = 1;
    end else if (m_q.size() != 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_q.delete();
        m_idle = 0;
        m_to = 1;
      end
    end
  endfunction

  function automatic logic [127:0] exp_block();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m_mem[i];
    return r;
  endfunction

  task automatic compare_all();
    chk("block_out",   block_out,   exp_block());
    chk("block_valid", block_valid, m_held);
    chk("byte_count",  byte_count,  m_held ? 16 : m_q.size());
    chk("overrun",     overrun,     m_ovr);
    chk("timeout",     timeout,     m_to);
  endtask

  task automatic cyc(input bit dv, input logic [7:0] d, input bit rdy);
    @(negedge clk);
    data_valid  = dv;
    data_in     = d;
    block_ready = rdy;
    @(posedge clk);
    model_step(dv, d, rdy);
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    data_valid  = 1'b0;
    block_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_block_out", block_out, 128'h0);
    chk("rst_valid", block_valid, 1'b0);
    chk("rst_count", byte_count, 5'd0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_to", timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, first + 8'(i), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic uart_send(input logic [7:0] b);
    ser = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser = b[i];
      repeat (BIT) @(negedge clk);
    end
    ser = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  // Bench-side serial receiver: samples mid-bit and issues a one-cycle strobe per frame.
  initial begin : rx_path
    logic [7:0] rxb;
    rxb = '0;
    forever begin
      @(posedge clk);
      if (ser == 1'b0) begin
        repeat (BIT / 2) @(posedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (BIT) @(posedge clk);
          rxb[b] = ser;
        end
        repeat (BIT) @(posedge clk);
        @(negedge clk);
        d2  = rxb;
        dv2 = 1'b1;
        @(negedge clk);
        dv2 = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    model_reset();
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    rst2 = 1'b0;
    fork
      begin : dut1_tests
        send_seq(8'h00, 16);
        chk("full_valid", block_valid, 1'b1);
        chk("full_block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
        chk("full_count", byte_count, 5'd16);
        cyc(1'b0, 8'h00, 1'b1);
        chk("hs_valid", block_valid, 1'b0);
        chk("hs_count", byte_count, 5'd0);

        send_seq(8'h30, 16);
        cyc(1'b1, 8'hAA, 1'b0);
        chk("ovr_pulse", overrun, 1'b1);
        chk("ovr_block", block_out, 128'h303132333435363738393A3B3C3D3E3F);
        chk("ovr_count", byte_count, 5'd16);
        chk("ovr_valid", block_valid, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ovr_one_cycle", overrun, 1'b0);

        cyc(1'b1, 8'h5C, 1'b1);
        chk("sim_valid", block_valid, 1'b0);
        chk("sim_count", byte_count, 5'd1);
        chk("sim_byte0", block_out[127:120], 8'h5C);
        chk("sim_ovr", overrun, 1'b0);

        pulse_reset();
        send_seq(8'hC0, 5);
        idle(TMO - 1);
        chk("to_early", timeout, 1'b0);
        idle(1);
        chk("to_pulse", timeout, 1'b1);
        chk("to_count", byte_count, 5'd0);
        idle(1);
        chk("to_one_cycle", timeout, 1'b0);
        send_seq(8'h10, 16);
        chk("to_clean_block", block_out, 128'h101112131415161718191A1B1C1D1E1F);
        chk("to_clean_valid", block_valid, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);

        send_seq(8'h60, 3);
        idle(TMO - 1);
        cyc(1'b1, 8'h77, 1'b0);
        chk("race_no_to", timeout, 1'b0);
        chk("race_count", byte_count, 5'd4);

        send_seq(8'h80, 3);
        pulse_reset();
        send_seq(8'hF0, 16);
        chk("post_rst_block", block_out, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        cyc(1'b0, 8'h00, 1'b1);

        for (int it = 0; it < 1500; it++) begin
          if ($urandom_range(0, 99) < 3) begin
            int len;
            len = $urandom_range(TMO - 20, TMO + 20);
            for (int k = 0; k < len; k++) cyc(1'b0, 8'h00, ($urandom_range(0, 9) < 2));
          end else begin
            cyc(($urandom_range(0, 9) < 4), 8'($urandom), ($urandom_range(0, 9) < 3));
          end
        end
      end
      begin : e2e
        string      msg;
        logic [127:0] exp2;
        int         waited;
        msg  = "A50123456789ABCD";
        exp2 = '0;
        for (int i = 0; i < 16; i++) begin
          exp2[127-8*i -: 8] = msg[i];
          @(negedge clk);
          uart_send(msg[i]);
        end
        waited = 0;
        while (!block_valid2 && waited < 3000) begin
          @(posedge clk);
          waited++;
        end
        #1;
        chk("e2e_valid", block_valid2, 1'b1);
        chk("e2e_first_two", block_out2[127:112], 16'h4135);
        chk("e2e_block", block_out2, exp2);
        chk("e2e_count", byte_count2, 5'd16);
      end
    join
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_block_assembler.md
# uart_block_assembler

Collects the byte stream from the UART receiver (`data_out`/`valid`) into 128-bit blocks for the AES core. It sits directly downstream of `uart_rx` and presents each completed block on a valid/ready handshake. It drops partial blocks after an inter-byte timeout. It flags bytes lost because the previous block has not yet been accepted.

## Interface
- `TIMEOUT_CYCLES`, default 43_400: idle clocks after a byte before a partial block is discarded. This is 10 byte times at 50 MHz / 115200 baud. 0 disables the timeout.
- `clk`  in  1  system clock, 50 MHz, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  8  received byte; connects to `uart_rx.data_out`.
- `data_valid`  in  1  one-cycle strobe; connects to `uart_rx.valid`.
- `block_ready`  in  1  AES core can accept a block.
- `block_out`  out  128  assembled block; the first byte received occupies `[127:120]`.
- `block_valid`  out  1  `block_out` holds a complete block.
- `byte_count`  out  5  bytes captured in the current block, 0..16.
- `overrun`  out  1  one-cycle pulse when a byte is dropped.
- `timeout`  out  1  one-cycle pulse when a partial block is discarded.

## Operation
- Two states: COLLECT (reset state) and HOLD.
- **COLLECT, byte arrives** (`data_valid`=1 at an edge):
  - byte n (0-based) is written to `block_out[127-8n -: 8]`;
  - `byte_count` increments;
  - the timeout counter clears.
- **COLLECT, 16th byte captured:** go to HOLD. `block_valid`=1 and `byte_count`=16.
- **HOLD:**
  - `block_out` is frozen.
  - `block_valid && block_ready` at an edge completes the handshake: go to COLLECT, `block_valid` drops to 0, `byte_count` goes to 0.
  - `block_ready` may be high before `block_valid`. Only the AND matters.
- **Simultaneous handshake and `data_valid` in HOLD:**
  - the byte is captured as byte 0 of the next block, so `byte_count` becomes 1;
  - it is not an overrun;
  - `block_out[127:120]` takes the new byte while `block_valid` falls in the same edge.
- **Overrun:** `data_valid` in HOLD without a handshake in that cycle. The byte is discarded, `overrun` pulses for one cycle, and the state is otherwise unchanged.
- **Timeout:**
  - In COLLECT with `byte_count` in 1..15, a counter increments on each clock without `data_valid`.
  - When it reaches `TIMEOUT_CYCLES`, then: `byte_count` goes to 0, the counter clears, and `timeout` pulses for one cycle.
  - Stale bits in `block_out` are don't-care; they are overwritten by the next block.
  - The counter does not run while `byte_count`=0 or in HOLD.
  - If `data_valid` arrives on the same edge as expiry, the byte wins: it is captured and no timeout occurs.
- **Counter width:** the timeout counter is $clog2(`TIMEOUT_CYCLES`+1) bits and must not wrap.

## Timing
- Reset values, applied immediately on `rst` (no clock needed): `block_out`=0, `block_valid`=0, `byte_count`=0, `overrun`=0, `timeout`=0, state COLLECT, timeout counter 0.
- Reset mid-block or in HOLD discards everything. The first byte after reset release is byte 0.
- **Latency:** `block_valid` is registered. It rises on the same edge that captures the 16th byte, so it is visible one cycle after the cycle in which that `data_valid` was high.
- `byte_count` and `block_out` update on the capture edge.
- `overrun` and `timeout` are high for exactly one clock per event.
- Back-to-back `data_valid` on consecutive cycles must be accepted, even though `uart_rx` never produces it.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Full block:** after reset, send bytes 0x00..0x0F, with `block_ready`=0.
  - Required: `block_valid`=1 one cycle after the 16th strobe.
  - Required: `block_out`=0x000102030405060708090A0B0C0D0E0F and `byte_count`=16.
  - Then raise `block_ready` for one cycle. Required: `block_valid`=0 and `byte_count`=0 on the next edge.
- **Overrun:** hold a block with `block_ready`=0, then strobe 0xAA.
  - Required: `overrun` pulses for 1 cycle.
  - Required: `block_out` unchanged, `byte_count`=16, `block_valid` still 1.
- **Simultaneous handshake and byte:** in HOLD, assert `block_ready` and `data_valid` with 0x5C on the same edge.
  - Required: `block_valid`=0, `byte_count`=1, `block_out[127:120]`=0x5C, `overrun`=0.
- **Timeout:** use `TIMEOUT_CYCLES`=100 and send 5 bytes.
  - After the 5th byte, idle for 99 cycles. Required: `timeout`=0.
  - Idle 1 more cycle. Required: `timeout` pulses and `byte_count`=0.
  - Then send 16 bytes 0x10..0x1F. Required: a clean block 0x101112…1F.
- **Timeout race:** with `TIMEOUT_CYCLES`=100, 3 bytes captured, deliver a byte on exactly the expiry edge.
  - Required: no `timeout` pulse and `byte_count`=4.
- **Reset mid-block:** after 7 bytes, pulse `rst` asynchronously between clock edges.
  - Required: all outputs are 0 immediately.
  - Then 16 bytes 0xF0..0xFF produce `block_out`=0xF0F1…FF.
- **End-to-end:** `uart_rx` serial path at 434 clocks/bit, sending "A5" followed by 14 more characters.
  - Required: `block_out[127:112]`=0x4135.
